// File: rtl/cond_eval_unit.sv
// cond_eval_unit
//   Multi-lane ID-stage condition evaluator. Owns the architectural NZCV
//   status register and evaluates the 4-bit ARM condition field of up to
//   LANES instructions per cycle. Results are registered behind a
//   valid/ready handshake. The unit stalls on flag updates that are still
//   in flight in EXE.
//
//   Build option COND_FLAG_FWD_EN:
//     defined   - a flag write in the acceptance cycle is forwarded into the
//                 evaluation, so the write causes no stall.
//     undefined - acceptance waits for the flag write to land in sr_q.
//
// Parameters
//   LANES  instructions evaluated per cycle (1..4)
//   CNT_W  width of the skipped-instruction counter
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     upstream handshake (in_ready is independent of in_valid)
//   in_cond               lane i condition in bits [4i+3:4i]
//   in_lane_en            lane holds a real instruction
//   out_valid/out_ready   downstream handshake
//   out_pass              lane i executes (0 for disabled lanes)
//   flag_we/mask/wdata    EXE flag write, {N,Z,C,V} order
//   flag_pend             flag-setting instruction in EXE, result not ready
//   sr_q                  current {N,Z,C,V}
//   skip_cnt              saturating count of enabled lanes that failed
module cond_eval_unit #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*LANES-1:0] in_cond,
  input  logic [LANES-1:0]   in_lane_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_pass,
  input  logic               flag_we,
  input  logic [3:0]         flag_mask,
  input  logic [3:0]         flag_wdata,
  input  logic               flag_pend,
  output logic [3:0]         sr_q,
  output logic [CNT_W-1:0]   skip_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               accept;
  logic               fwd_block;
  logic [3:0]         merged_flags;
  logic [3:0]         eval_flags;
  logic [LANES-1:0]   pass_d;
  logic [2:0]         fail_cnt;
  logic [CNT_W:0]     skip_sum;

  // Flags as they will look after this cycle's EXE write.
  assign merged_flags = (flag_mask & flag_wdata) | (~flag_mask & sr_q);

`ifdef COND_FLAG_FWD_EN
  assign eval_flags = flag_we ? merged_flags : sr_q;
  assign fwd_block  = 1'b0;
`else
  // Without forwarding, a bundle must not see stale flags: hold it off
  // until the write has landed in sr_q.
  assign eval_flags = sr_q;
  assign fwd_block  = flag_we;
`endif

  assign out_valid = (state_q == FULL);
  assign in_ready  = ~rst & (~out_valid | out_ready) & ~flag_pend & ~fwd_block;
  assign accept    = in_valid & in_ready;

  // f = {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // NOTE: every signal written here gets a default before any conditional
  // logic, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    pass_d   = '0;
    fail_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      pass_d[i] = in_lane_en[i] & cond_pass(in_cond[4*i +: 4], eval_flags);
      fail_cnt  = fail_cnt + {2'b00, (in_lane_en[i] & ~pass_d[i])};
    end
  end

  // One extra bit catches the carry so the counter can saturate instead of wrap.
  assign skip_sum = {1'b0, skip_cnt} + (CNT_W+1)'(fail_cnt);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: all architectural state, including the result register, is reset
  // so a reset mid-transfer leaves nothing of the old bundle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pass <= '0;
      sr_q     <= '0;
      skip_cnt <= '0;
    end else begin
      if (accept) begin
        out_pass <= pass_d;
        skip_cnt <= skip_sum[CNT_W] ? {CNT_W{1'b1}} : skip_sum[CNT_W-1:0];
      end
      if (flag_we) sr_q <= merged_flags;
    end
  end

endmodule

// File: tb/tb_cond_eval_unit.sv
module tb_cond_eval_unit;

  localparam int LANES = 2;
  localparam int CNT_W = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef COND_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [4*LANES-1:0] in_cond;
  logic [LANES-1:0]   in_lane_en;
  logic               out_valid;
  logic               out_ready;
  logic [LANES-1:0]   out_pass;
  logic               flag_we;
  logic [3:0]         flag_mask;
  logic [3:0]         flag_wdata;
  logic               flag_pend;
  logic [3:0]         sr_q;
  logic [CNT_W-1:0]   skip_cnt;

  cond_eval_unit #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cond   (in_cond),
    .in_lane_en(in_lane_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pass  (out_pass),
    .flag_we   (flag_we),
    .flag_mask (flag_mask),
    .flag_wdata(flag_wdata),
    .flag_pend (flag_pend),
    .sr_q      (sr_q),
    .skip_cnt  (skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference condition semantics in ARM's canonical form: the upper three
  // bits pick a base test, bit 0 inverts it (except for the always pair).
  function automatic bit ref_cond(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond[3:1] == 3'd7) return !cond[0];
    return base ^ cond[0];
  endfunction

  // Behavioural model state
  logic [3:0]       m_sr;
  logic             m_valid;
  logic [LANES-1:0] m_pass;
  int               m_skip;
  logic             dut_acc;

  // One clock: sample handshake at the falling edge, advance the model,
  // then compare registered outputs just after the rising edge.
  task automatic cycle();
    logic       exp_rdy, acc;
    logic [3:0] merged, f;
    int         nf;
    @(negedge clk);
    exp_rdy = !rst && (!m_valid || out_ready) && !flag_pend && (FWD || !flag_we);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    dut_acc = in_valid && in_ready;
    acc     = in_valid && exp_rdy;
    merged  = (flag_mask & flag_wdata) | (~flag_mask & m_sr);
    f       = (FWD && flag_we) ? merged : m_sr;
    if (rst) begin
      m_sr = '0; m_valid = 1'b0; m_pass = '0; m_skip = 0;
    end else begin
      if (acc) begin
        nf = 0;
        for (int i = 0; i < LANES; i++) begin
          m_pass[i] = in_lane_en[i] && ref_cond(in_cond[4*i +: 4], f);
          if (in_lane_en[i] && !m_pass[i]) nf++;
        end
        m_skip  = (m_skip + nf > CNT_MAX) ? CNT_MAX : m_skip + nf;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (flag_we) m_sr = merged;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_pass", 32'(out_pass), 32'(m_pass));
    check("sr_q", 32'(sr_q), 32'(m_sr));
    check("skip_cnt", 32'(skip_cnt), 32'(m_skip));
  endtask

  typedef struct {
    logic [3:0] nzcv;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t spot[12];
  vec_t sweep[256];

  // Load flags, then present one bundle with the same condition on both lanes.
  task automatic apply_vec(input string name, input vec_t v, input logic [LANES-1:0] en);
    flag_we = 1'b1; flag_mask = 4'hF; flag_wdata = v.nzcv; in_valid = 1'b0;
    cycle();
    flag_we = 1'b0; in_valid = 1'b1; in_cond = {v.cond, v.cond}; in_lane_en = en;
    cycle();
    check({name, "_acc"}, 32'(dut_acc), 32'd1);
    check(name, 32'(out_pass), 32'(en & {LANES{v.exp}}));
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [LANES-1:0] held;

  initial begin
    // Stimulus tables
    spot[0]  = '{4'b0110, 4'b1001, 1'b1}; // LS, C=1 Z=1
    spot[1]  = '{4'b0010, 4'b1001, 1'b0}; // LS, C=1 Z=0
    spot[2]  = '{4'b0010, 4'b1000, 1'b1}; // HI
    spot[3]  = '{4'b0100, 4'b1101, 1'b1}; // LE, Z=1 N=V
    spot[4]  = '{4'b1001, 4'b1101, 1'b0}; // LE, Z=0 N=V
    spot[5]  = '{4'b1000, 4'b1011, 1'b1}; // LT
    spot[6]  = '{4'b1001, 4'b1100, 1'b1}; // GT
    spot[7]  = '{4'b0000, 4'b1111, 1'b0}; // NV
    spot[8]  = '{4'b1111, 4'b1111, 1'b0}; // NV
    spot[9]  = '{4'b0000, 4'b1110, 1'b1}; // AL
    spot[10] = '{4'b0000, 4'b0000, 1'b0}; // EQ, Z=0
    spot[11] = '{4'b1010, 4'b1010, 1'b0}; // GE, N!=V
    for (int i = 0; i < 256; i++) begin
      sweep[i].nzcv = 4'(i >> 4);
      sweep[i].cond = 4'(i);
      sweep[i].exp  = ref_cond(sweep[i].cond, sweep[i].nzcv);
    end

    rst = 1'b1; in_valid = 1'b0; in_cond = '0; in_lane_en = '0; out_ready = 1'b1;
    flag_we = 1'b0; flag_mask = '0; flag_wdata = '0; flag_pend = 1'b0;
    m_sr = '0; m_valid = 1'b0; m_pass = '0; m_skip = 0; dut_acc = 1'b0;

    // Reset
    in_valid = 1'b1; in_lane_en = 2'b11;
    cycle();
    cycle();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pass", 32'(out_pass), 32'd0);
    check("rst_sr_q", 32'(sr_q), 32'd0);
    check("rst_skip_cnt", 32'(skip_cnt), 32'd0);
    rst = 1'b0; in_valid = 1'b0;

    // First bundle: EQ/NE with Z=1
    flag_we = 1'b1; flag_mask = 4'hF; flag_wdata = 4'b0100;
    cycle();
    flag_we = 1'b0; in_valid = 1'b1; in_lane_en = 2'b11; in_cond = 8'h10;
    cycle();
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_out_pass", 32'(out_pass), 32'b01);
    check("first_skip_cnt", 32'(skip_cnt), 32'd1);
    in_valid = 1'b0;
    cycle();

    foreach (spot[i]) apply_vec($sformatf("spot%0d", i), spot[i], 2'b01);
    foreach (sweep[i]) apply_vec($sformatf("sweep_nzcv%0h_c%0h", sweep[i].nzcv, sweep[i].cond),
                                 sweep[i], 2'b11);
    cycle();

    // Flag write in the acceptance cycle
    flag_we = 1'b1; flag_mask = 4'hF; flag_wdata = 4'b0000;
    cycle();
    flag_wdata = 4'b0100; in_valid = 1'b1; in_cond = 8'h00; in_lane_en = 2'b01;
    cycle();
`ifdef COND_FLAG_FWD_EN
    check("fwd_acc", 32'(dut_acc), 32'd1);
    check("fwd_pass", 32'(out_pass), 32'b01);
    flag_we = 1'b0; in_valid = 1'b0;
`else
    check("nofwd_stall", 32'(dut_acc), 32'd0);
    flag_we = 1'b0;
    cycle();
    check("nofwd_acc", 32'(dut_acc), 32'd1);
    check("nofwd_pass", 32'(out_pass), 32'b01);
    in_valid = 1'b0;
`endif
    cycle();

    // flag_pend stall for three cycles
    in_valid = 1'b1; flag_pend = 1'b1; in_cond = 8'hEE; in_lane_en = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("pend_stall", 32'(dut_acc), 32'd0);
      check("pend_out_valid", 32'(out_valid), 32'd0);
    end
    flag_pend = 1'b0;
    cycle();
    check("pend_release_acc", 32'(dut_acc), 32'd1);
    check("pend_release_pass", 32'(out_pass), 32'b01);

    // Stalled FULL output with flag writes and a different pending bundle
    held = out_pass;
    out_ready = 1'b0; in_cond = 8'hFF; in_lane_en = 2'b11;
    flag_we = 1'b1; flag_mask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      flag_wdata = 4'($urandom);
      cycle();
      check("hold_no_acc", 32'(dut_acc), 32'd0);
      check("hold_pass", 32'(out_pass), 32'(held));
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    flag_we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_cond = (i % 2 == 0) ? 8'hEE : 8'hFF;
      cycle();
      check("b2b_acc", 32'(dut_acc), 32'd1);
      check("b2b_pass", 32'(out_pass), (i % 2 == 0) ? 32'b11 : 32'b00);
    end
    in_valid = 1'b0;
    cycle();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_cond    = 8'($urandom);
      in_lane_en = 2'($urandom);
      flag_we    = ($urandom_range(0, 3) == 0);
      flag_mask  = 4'($urandom);
      flag_wdata = 4'($urandom);
      flag_pend  = ($urandom_range(0, 6) == 0);
      cycle();
    end

    // Reset while a result is held
    in_valid = 1'b1; out_ready = 1'b1; flag_pend = 1'b0; in_cond = 8'hEE; in_lane_en = 2'b11;
    flag_we = 1'b1; flag_mask = 4'hF; flag_wdata = 4'hF;
    cycle();
    out_ready = 1'b0; flag_we = 1'b0; rst = 1'b1;
    cycle();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_pass", 32'(out_pass), 32'd0);
    check("midrst_sr_q", 32'(sr_q), 32'd0);
    check("midrst_skip_cnt", 32'(skip_cnt), 32'd0);
    rst = 1'b0; out_ready = 1'b1;

    // Saturation: preload to max-1 with NV bundles, then overflow
    in_valid = 1'b1; in_cond = 8'hFF; in_lane_en = 2'b11;
    for (int i = 0; i < CNT_MAX / 2; i++) cycle();
    check("sat_preload", 32'(skip_cnt), 32'(CNT_MAX - 1));
    cycle();
    check("sat_reach", 32'(skip_cnt), 32'(CNT_MAX));
    cycle();
    check("sat_hold", 32'(skip_cnt), 32'(CNT_MAX));
    in_valid = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_eval_unit.md
# cond_eval_unit

Multi-lane, pipelined condition-evaluation unit for the ID stage. It owns the architectural NZCV status register and evaluates the 4-bit ARM condition field of up to LANES instructions per cycle. It registers the per-lane pass/fail result behind a valid/ready handshake and stalls or forwards around in-flight flag updates from EXE. It supersedes the single-lane combinational condition check.

## Interface
- LANES, 1, instructions evaluated per cycle (1..4)
- CNT_W, 16, width of the skipped-instruction counter

- clk  in  1  single clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a bundle
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_cond  in  4*LANES  lane i condition in bits [4i+3:4i]
- in_lane_en  in  LANES  lane holds a real instruction
- out_valid  out  1  result bundle valid
- out_ready  in  1  downstream accepts result
- out_pass  out  LANES  lane i executes (0 for disabled lanes)
- flag_we  in  1  EXE writes flags this cycle
- flag_mask  in  4  per-flag write enable {N,Z,C,V}
- flag_wdata  in  4  new {N,Z,C,V}
- flag_pend  in  1  a flag-setting instruction is in EXE but its result is not yet valid
- sr_q  out  4  current {N,Z,C,V}
- skip_cnt  out  CNT_W  count of enabled lanes that failed their condition

## Operation
- Status register: on flag_we, sr_q[k] <= flag_mask[k] ? flag_wdata[k] : sr_q[k].
- Evaluation flags F: sr_q, or the merged next value (mask applied to flag_wdata) when forwarding applies (see Configuration).
- Condition decode on F:
  - 0000 EQ z, 0001 NE ~z, 0010 CS c, 0011 CC ~c
  - 0100 MI n, 0101 PL ~n, 0110 VS v, 0111 VC ~v
  - 1000 HI c&~z, 1001 LS ~c|z
  - 1010 GE n==v, 1011 LT n!=v
  - 1100 GT ~z&(n==v), 1101 LE z|(n!=v)
  - 1110 AL 1, 1111 NV 0
- out_pass[i] = in_lane_en[i] & decode(in_cond lane i), registered on acceptance.
- skip_cnt += popcount(in_lane_en & ~pass) on each accepted bundle. It saturates at all-ones; no wrap.
- State: output register is EMPTY (out_valid=0) or FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready with no accept.
  - FULL→FULL on simultaneous out_ready and accept; the new bundle replaces the old one in the same edge.

## Timing
- Reset values: out_valid=0, out_pass=0, sr_q=0000, skip_cnt=0.
- in_ready is 0 during the reset cycle.
- Latency: one cycle from acceptance to out_valid.
- in_ready = (~out_valid | out_ready) & ~flag_pend, plus the extra term under Configuration. in_ready never depends on in_valid.
- out_pass is held stable while out_valid & ~out_ready.
- A flag_we arriving while FULL and stalled does not alter the held out_pass.
- flag_pend & flag_we in the same cycle: flag_pend wins for stalling; the write still updates sr_q.
- rst mid-transfer drops the held result and clears sr_q; no partial update survives.

## Configuration
- COND_FLAG_FWD_EN defined:
  - If flag_we is high in the acceptance cycle, evaluation uses the merged flag_wdata/sr_q value.
  - No extra stall.
- COND_FLAG_FWD_EN undefined:
  - in_ready additionally requires ~flag_we.
  - Evaluation always uses sr_q, so the bundle is accepted one cycle later, after the write lands.
- sr_q update timing is identical in both builds.

## Test plan
- Reset, then LANES=2, cond={0000,0001}, sr_q=0100 (Z=1) → one cycle later out_valid=1, out_pass=2'b01. skip_cnt=1.
- All 16 codes against all 16 NZCV values. Check LS with C=1,Z=1 → pass=1 and LE with Z=1,N=V → pass=1. Check 1111 → 0 and 1110 → 1.
- Same cycle flag_we=1, mask=1111, wdata=0100, cond=EQ, sr_q=0000:
  - With COND_FLAG_FWD_EN: accepted that cycle, pass=1.
  - Without: in_ready=0 that cycle; accepted next cycle, pass=1.
- flag_pend=1 for 3 cycles with in_valid=1 → in_ready=0 throughout, out_valid=0; accepted on the 4th cycle.
- Hold out_ready=0 with FULL output while issuing flag_we → out_pass unchanged and in_ready=0. Release out_ready → back-to-back bundles at one per cycle.
- Preload skip_cnt to max-1 via failing bundles, then issue 2 failing lanes → skip_cnt saturates at all-ones.
